// File: rtl/shift_pkg.sv
// Shared types and widths for the serial right-shift unit.
package shift_pkg;

    localparam int unsigned XLEN    = 32;
    localparam int unsigned SHAMT_W = 5;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } shr_state_t;

endpackage

// File: rtl/shift_right_step.sv
// Combinational single-position right shift; fill_i enters at the MSB.
module shift_right_step #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] data_i,
    input  logic             fill_i,
    output logic [WIDTH-1:0] data_o
);

    // The LSB is shifted out and intentionally discarded.
    logic unused_lsb;
    assign unused_lsb = data_i[0];

    always_comb begin
        data_o = {fill_i, data_i[WIDTH-1:1]};
    end

endmodule

// File: rtl/shift_right_serial.sv
// Multi-cycle SRL/SRA unit, one bit position per clock, start/done handshake.
// Define SHR_ARITH_EN to honour `arith` (sign fill); otherwise every shift zero-fills.
module shift_right_serial #(
    parameter int unsigned WIDTH   = shift_pkg::XLEN,
    parameter int unsigned SHAMT_W = shift_pkg::SHAMT_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               start,
    input  logic [WIDTH-1:0]   in,
    input  logic [SHAMT_W-1:0] shamt,
    input  logic               arith,
    output logic               busy,
    output logic               done,
    output logic [WIDTH-1:0]   result
);

    import shift_pkg::shr_state_t;
    import shift_pkg::IDLE;
    import shift_pkg::SHIFT;
    import shift_pkg::DONE;

    shr_state_t         state_q, state_d;
    logic [WIDTH-1:0]   work_q, work_d;
    logic [SHAMT_W-1:0] cnt_q, cnt_d;
    logic               fill_q, fill_d;
    logic [WIDTH-1:0]   result_q, result_d;

    logic               arith_fill;
    logic               step_fill;
    logic [WIDTH-1:0]   step_out;
    logic               accept;

`ifdef SHR_ARITH_EN
    assign arith_fill = arith;
`else
    logic unused_arith;
    assign unused_arith = arith;
    assign arith_fill   = 1'b0;
`endif

    assign step_fill = fill_q & work_q[WIDTH-1];

    shift_right_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .data_i (work_q),
        .fill_i (step_fill),
        .data_o (step_out)
    );

    always_comb begin
        state_d  = state_q;
        work_d   = work_q;
        cnt_d    = cnt_q;
        fill_d   = fill_q;
        result_d = result_q;
        accept   = 1'b0;

        unique case (state_q)
            IDLE: begin
                accept = start & ~flush;
            end
            SHIFT: begin
                work_d = step_out;
                cnt_d  = cnt_q - SHAMT_W'(1);
                if (cnt_q == SHAMT_W'(1)) begin
                    state_d  = DONE;
                    result_d = step_out;
                end
            end
            DONE: begin
                accept  = start & ~flush;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (accept) begin
            work_d = in;
            cnt_d  = shamt;
            fill_d = arith_fill;
            if (shamt == '0) begin
                state_d  = DONE;
                result_d = in;
            end else begin
                state_d = SHIFT;
            end
        end

        // Abort: the in-flight result is discarded and the visible result is kept.
        if (flush) begin
            state_d  = IDLE;
            cnt_d    = '0;
            result_d = result_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            work_q   <= '0;
            cnt_q    <= '0;
            fill_q   <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            work_q   <= work_d;
            cnt_q    <= cnt_d;
            fill_q   <= fill_d;
            result_q <= result_d;
        end
    end

    always_comb begin
        busy   = (state_q == SHIFT);
        done   = (state_q == DONE);
        result = result_q;
    end

endmodule

// File: tb/tb_shift_right_serial.sv
// Scoreboard bench for shift_right_serial: directed cases followed by random operations.
module tb_shift_right_serial;

`ifdef SHR_ARITH_EN
    localparam bit ArithEn = 1'b1;
`else
    localparam bit ArithEn = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        flush;
    logic        start;
    logic [31:0] in_d;
    logic [4:0]  shamt;
    logic        arith;
    logic        busy;
    logic        done;
    logic [31:0] result;

    shift_right_serial #(
        .WIDTH   (32),
        .SHAMT_W (5)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .flush  (flush),
        .start  (start),
        .in     (in_d),
        .shamt  (shamt),
        .arith  (arith),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        int          n;
        bit          ar;
        bit          b2b;
        int          flush_at;
        int          junk_at;
        bit          flush_done;
    } op_t;

    logic [31:0] exp_q[$];
    logic [31:0] last_res;
    bit          exp_busy;
    bit          exp_done;
    int          n_cmp;
    int          n_bad;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    // Reference: RISC-V shift semantics straight from the operator definitions.
    function automatic logic [31:0] model(input logic [31:0] d, input int n, input bit ar);
        logic signed [31:0] s;
        s = d;
        if (ArithEn && ar) return 32'(s >>> n);
        return d >> n;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int k);
        start = 1'b0;
        for (int i = 0; i <= k; i++) begin
            step();
            exp_busy = 1'b0;
            exp_done = 1'b0;
        end
    endtask

    // Entered one tick after an edge with the DUT in IDLE or DONE.
    task automatic do_op(input op_t op, output bit in_done);
        bit flushed;
        flushed = 1'b0;
        start = 1'b1;
        in_d  = op.data;
        shamt = op.n[4:0];
        arith = op.ar;
        exp_q.push_back(model(op.data, op.n, op.ar));
        step();
        start    = 1'b0;
        in_d     = $urandom;
        shamt    = 5'($urandom);
        arith    = 1'($urandom);
        exp_busy = (op.n != 0);
        exp_done = (op.n == 0);
        for (int i = 1; i <= op.n; i++) begin
            if (i == op.junk_at) start = 1'b1;
            if (i == op.flush_at) begin
                flush = 1'b1;
                start = 1'b1;
            end
            step();
            start = 1'b0;
            flush = 1'b0;
            if (i == op.flush_at) begin
                void'(exp_q.pop_back());
                exp_busy = 1'b0;
                exp_done = 1'b0;
                flushed  = 1'b1;
                break;
            end
            exp_busy = (i < op.n);
            exp_done = (i == op.n);
        end
        in_done = ~flushed;
        if (!flushed && op.flush_done) begin
            flush = 1'b1;
            start = 1'b1;
            step();
            flush    = 1'b0;
            start    = 1'b0;
            exp_done = 1'b0;
            in_done  = 1'b0;
        end
    endtask

    // Monitor: compares handshake outputs every cycle and pops the scoreboard on done.
    initial begin
        @(posedge clk);
        forever begin
            @(negedge clk);
            check("busy", 32'(busy), 32'(exp_busy));
            check("done", 32'(done), 32'(exp_done));
            if (done) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL done_unexpected at %0t: got done=1, expected no pending op", $time);
                end else begin
                    last_res = exp_q.pop_front();
                end
            end
            check("result", result, last_res);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected bench completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        op_t ops[$];
        op_t op;
        bit  in_done;

        n_cmp    = 0;
        n_bad    = 0;
        last_res = '0;
        exp_busy = 1'b0;
        exp_done = 1'b0;
        rst      = 1'b1;
        flush    = 1'b0;
        start    = 1'b1;
        in_d     = 32'hDEAD_BEEF;
        shamt    = 5'd0;
        arith    = 1'b0;
        step();
        step();
        rst   = 1'b0;
        start = 1'b0;
        idle(1);

        ops.push_back('{32'hF000_0010, 4, 1'b0, 1'b0, 0, 0, 1'b0});
        ops.push_back('{32'h8000_0000, 31, 1'b1, 1'b0, 0, 0, 1'b0});
        ops.push_back('{32'h1234_5678, 0, 1'b0, 1'b1, 0, 0, 1'b0});
        ops.push_back('{32'h1234_5678, 1, 1'b0, 1'b0, 0, 0, 1'b0});
        ops.push_back('{32'hCAFE_F00D, 10, 1'b1, 1'b0, 3, 0, 1'b0});
        ops.push_back('{32'hA5A5_A5A5, 6, 1'b1, 1'b0, 0, 2, 1'b0});
        ops.push_back('{32'h8765_4321, 2, 1'b1, 1'b0, 0, 0, 1'b1});
        ops.push_back('{32'hFFFF_0000, 0, 1'b1, 1'b0, 0, 0, 1'b0});
        for (int k = 0; k < 70; k++) begin
            op.data       = $urandom;
            op.n          = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 2) : $urandom_range(0, 31);
            op.ar         = 1'($urandom);
            op.b2b        = ($urandom_range(0, 2) == 0);
            op.flush_at   = (op.n > 0 && $urandom_range(0, 7) == 0) ? $urandom_range(1, op.n) : 0;
            op.junk_at    = (op.n > 0 && $urandom_range(0, 3) == 0) ? $urandom_range(1, op.n) : 0;
            op.flush_done = ($urandom_range(0, 9) == 0);
            ops.push_back(op);
        end

        foreach (ops[i]) begin
            do_op(ops[i], in_done);
            if (!(ops[i].b2b && in_done)) idle($urandom_range(0, 2));
        end

        idle(3);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
